rf_writeback: RTL and testbench
===============================

// Module: rf_writeback
// PURPOSE
//  Write-side master for the 32x32 register file: merges the single-cycle pipeline result
//  (port A) with long-latency results (port B: load/mul) onto the one regfile write port.
//  B results queue in a small FIFO. A busy scoreboard drives decode stall; a bypass serves
//  the in-flight write. A starvation flag asks the pipeline for a bubble.
// PARAMETERS
//  DEPTH       4   port-B FIFO entries (power of 2, >=2)
//  STARVE_MAX  8   cycles the B head may lose arbitration before b_starve asserts
// PORTS
//  clk        in   1   clock, all state on posedge
//  rst_n      in   1   asynchronous active-low reset
//  a_valid    in   1   pipeline result valid; always accepted, no ready
//  a_rd       in   5   pipeline destination register
//  a_data     in   32  pipeline result
//  b_valid    in   1   long-latency result valid
//  b_ready    out  1   FIFO can accept; handshake = b_valid & b_ready
//  b_rd       in   5   long-latency destination register
//  b_data     in   32  long-latency result
//  rf_we      out  1   regfile write enable (registered)
//  rf_wa      out  5   regfile write address (registered)
//  rf_din     out  32  regfile write data (registered)
//  busy       out  32  bit r set while a queued B entry targets r (bit 0 always 0)
//  q_rs1      in   5   bypass query 1
//  q_rs2      in   5   bypass query 2
//  byp1_hit   out  1   rf_we & rf_wa==q_rs1 & q_rs1!=0 (combinational)
//  byp1_data  out  32  rf_din when byp1_hit, else 0
//  byp2_hit   out  1   as byp1 for q_rs2
//  byp2_data  out  32  as byp1 for q_rs2
//  b_starve   out  1   B head has waited >= STARVE_MAX cycles
// BEHAVIOUR
//  Reset (async, rst_n=0): rf_we=0, rf_wa=0, rf_din=0, FIFO empty, busy=0, starve cnt=0,
//   b_starve=0, b_ready=1 after release. Mid-operation reset discards queued B entries.
//  Arbitration each cycle, A strict priority:
//   - a_valid: output reg <= {a_rd!=0, a_rd, a_data}; FIFO not popped.
//   - else FIFO non-empty: pop head; output reg <= {head_rd!=0, head_rd, head_data}.
//   - else rf_we<=0; rf_wa/rf_din hold.
//  Writes to x0 never assert rf_we; x0 entries still pop and still enqueue.
//  Latency: input at edge N -> rf_we high in cycle after N -> regfile updated at edge N+1.
//   A enqueue-to-write min 2 edges from handshake (no FIFO bypass path).
//  FIFO: b_ready = !full, combinational from count. Push when b_valid&b_ready. Push+pop
//   in same cycle allowed when not full; count unchanged. Full: no push even with pop.
//   Pointers wrap modulo DEPTH; count width log2(DEPTH)+1.
//  busy[r] = OR over valid FIFO entries of (rd==r), r!=0; combinational from FIFO state.
//   Entry in output register is not busy; bypass covers it. Duplicate rds allowed; bit
//   clears only when last matching entry pops.
//  Ordering contract: decode stalls on busy, so a_valid with busy[a_rd]=1 is illegal;
//   bench asserts it never occurs. B results leave in FIFO order.
//  Starvation: cnt++ (saturating) when FIFO non-empty and a_valid; cnt<=0 on pop or empty.
//   b_starve = (cnt >= STARVE_MAX), registered view of cnt; deasserts the cycle after a pop.
//  Bypass compares against registered rf_wa/rf_we only, never FIFO contents.
// TESTING
//  1. Reset: rst_n=0 mid-burst with 3 B entries queued -> rf_we=0, busy=0, b_ready=1 at once.
//  2. A only: a_rd=5,a_data=0xDEADBEEF -> next cycle rf_we=1,rf_wa=5,rf_din=0xDEADBEEF;
//     q_rs1=5 -> byp1_hit=1, byp1_data=0xDEADBEEF; a_rd=0 -> rf_we=0.
//  3. Fill: push B rd=1..4 with a_valid held 1 -> b_ready=0 after 4th, busy=0x1E; drop
//     a_valid -> writes rd 1,2,3,4 in order on consecutive cycles, busy clears bit by bit.
//  4. Conflict: B head rd=7 queued, a_valid=1 for 8 cycles -> b_starve=1 on 9th cycle;
//     a_valid=0 -> rd=7 written, b_starve=0 next cycle.
//  5. Push+pop same cycle at count=2 -> count stays 2; at full, pop frees slot, b_ready=1 next.
//  6. Duplicate: B rd=9 twice -> busy[9] stays 1 until second entry pops; x0 B entry pops, no write.

Source files
------------

// File: rtl/rf_writeback.sv
// Regfile write master: port A (strict priority) and a queued port B share one registered write port.
// Latency is one edge A->write and at least two edges B handshake->write; b_ready drops only when the B queue is full.
module rf_writeback #(
   parameter int DEPTH      = 4,
   parameter int STARVE_MAX = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        a_valid,
   input  logic [4:0]  a_rd,
   input  logic [31:0] a_data,
   input  logic        b_valid,
   output logic        b_ready,
   input  logic [4:0]  b_rd,
   input  logic [31:0] b_data,
   output logic        rf_we,
   output logic [4:0]  rf_wa,
   output logic [31:0] rf_din,
   output logic [31:0] busy,
   input  logic [4:0]  q_rs1,
   input  logic [4:0]  q_rs2,
   output logic        byp1_hit,
   output logic [31:0] byp1_data,
   output logic        byp2_hit,
   output logic [31:0] byp2_data,
   output logic        b_starve
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int SW = $clog2(STARVE_MAX + 1);

   logic [4:0]       q_rd   [DEPTH];
   logic [31:0]      q_data [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic [SW-1:0]    starve_cnt;
   logic [DEPTH-1:0] ent_vld;

   logic full;
   logic empty;
   logic push;
   logic pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign b_ready = !full;
   assign push    = b_valid && b_ready;
   assign pop     = !a_valid && !empty;

   // A slot is live when its distance from the read pointer is below the fill count.
   for (genvar g = 0; g < DEPTH; g++) begin : g_vld
      logic [AW-1:0] off;
      assign off        = AW'(g) - rd_ptr;
      assign ent_vld[g] = ({1'b0, off} < count);
   end

   always_comb begin
      busy = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (ent_vld[i]) busy[q_rd[i]] = 1'b1;
      end
      busy[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (push) begin
         q_rd[wr_ptr]   <= b_rd;
         q_data[wr_ptr] <= b_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_we  <= 1'b0;
         rf_wa  <= '0;
         rf_din <= '0;
      end else if (a_valid) begin
         rf_we  <= (a_rd != 5'd0);
         rf_wa  <= a_rd;
         rf_din <= a_data;
      end else if (!empty) begin
         rf_we  <= (q_rd[rd_ptr] != 5'd0);
         rf_wa  <= q_rd[rd_ptr];
         rf_din <= q_data[rd_ptr];
      end else begin
         rf_we  <= 1'b0;
      end
   end

   // Counts consecutive cycles the queued head loses to port A.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt <= '0;
      end else if (!empty && a_valid) begin
         if (starve_cnt < SW'(STARVE_MAX)) starve_cnt <= starve_cnt + 1'b1;
      end else begin
         starve_cnt <= '0;
      end
   end

   assign b_starve  = (starve_cnt >= SW'(STARVE_MAX));

   assign byp1_hit  = rf_we && (rf_wa == q_rs1) && (q_rs1 != 5'd0);
   assign byp1_data = byp1_hit ? rf_din : 32'd0;
   assign byp2_hit  = rf_we && (rf_wa == q_rs2) && (q_rs2 != 5'd0);
   assign byp2_data = byp2_hit ? rf_din : 32'd0;

endmodule

// File: tb/tb_rf_writeback.sv
// Directed bench for rf_writeback with hand-computed expectations.
module tb_rf_writeback;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        a_valid;
   logic [4:0]  a_rd;
   logic [31:0] a_data;
   logic        b_valid;
   logic        b_ready;
   logic [4:0]  b_rd;
   logic [31:0] b_data;
   logic        rf_we;
   logic [4:0]  rf_wa;
   logic [31:0] rf_din;
   logic [31:0] busy;
   logic [4:0]  q_rs1;
   logic [4:0]  q_rs2;
   logic        byp1_hit;
   logic [31:0] byp1_data;
   logic        byp2_hit;
   logic [31:0] byp2_data;
   logic        b_starve;

   int n_chk  = 0;
   int n_pass = 0;
   int n_viol = 0;

   rf_writeback #(.DEPTH(4), .STARVE_MAX(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data),
      .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
      .rf_we(rf_we), .rf_wa(rf_wa), .rf_din(rf_din), .busy(busy),
      .q_rs1(q_rs1), .q_rs2(q_rs2),
      .byp1_hit(byp1_hit), .byp1_data(byp1_data),
      .byp2_hit(byp2_hit), .byp2_data(byp2_data),
      .b_starve(b_starve)
   );

   always #5 clk = ~clk;

   // Decode must never issue an A write to a register still owed by the B queue.
   always @(posedge clk) begin
      if (rst_n && a_valid && a_rd != 5'd0 && busy[a_rd]) n_viol++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; a_valid = 1'b0; a_rd = '0; a_data = '0;
      b_valid = 1'b0; b_rd = '0; b_data = '0; q_rs1 = '0; q_rs2 = '0;
      repeat (2) step();
      chk("rst_we", rf_we, 0);
      chk("rst_wa", rf_wa, 0);
      chk("rst_din", rf_din, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ready", b_ready, 1);
      chk("rst_starve", b_starve, 0);
      rst_n = 1'b1;
      step();

      // A only, plus bypass
      a_valid = 1; a_rd = 5; a_data = 32'hDEADBEEF; q_rs1 = 5; q_rs2 = 0;
      step();
      chk("a_we", rf_we, 1);
      chk("a_wa", rf_wa, 5);
      chk("a_din", rf_din, 32'hDEADBEEF);
      chk("byp1_hit", byp1_hit, 1);
      chk("byp1_data", byp1_data, 32'hDEADBEEF);
      chk("byp2_x0_hit", byp2_hit, 0);
      a_rd = 0; a_data = 32'h1234;
      step();
      chk("a_x0_we", rf_we, 0);
      chk("a_x0_din", rf_din, 32'h1234);
      chk("byp1_off", byp1_hit, 0);
      chk("byp1_off_data", byp1_data, 0);

      // Fill the queue while A holds the port
      a_rd = 10; b_valid = 1;
      for (int i = 1; i <= 4; i++) begin
         b_rd = 5'(i); b_data = 32'h100 + 32'(i);
         step();
         if (i == 3) chk("fill_ready3", b_ready, 1);
      end
      chk("fill_ready4", b_ready, 0);
      chk("fill_busy", busy, 32'h1E);
      chk("fill_a_wa", rf_wa, 10);
      b_valid = 0; a_valid = 0;
      for (int i = 1; i <= 4; i++) begin
         step();
         chk("drain_we", rf_we, 1);
         chk("drain_wa", rf_wa, 32'(i));
         chk("drain_din", rf_din, 32'h100 + 32'(i));
         chk("drain_busy", busy, 32'h1E & ~((32'h2 << i) - 32'h2));
      end
      chk("drain_ready", b_ready, 1);
      step();
      chk("drain_idle_we", rf_we, 0);
      chk("drain_idle_wa", rf_wa, 4);

      // Starvation
      a_valid = 1; a_rd = 11; b_valid = 1; b_rd = 7; b_data = 32'h777;
      step();
      b_valid = 0;
      chk("starve_busy", busy, 32'h80);
      for (int k = 1; k <= 8; k++) begin
         step();
         if (k == 7) chk("starve_7", b_starve, 0);
         if (k == 8) chk("starve_8", b_starve, 1);
      end
      a_valid = 0;
      step();
      chk("starve_pop_wa", rf_wa, 7);
      chk("starve_pop_din", rf_din, 32'h777);
      chk("starve_clear", b_starve, 0);
      chk("starve_busy_clr", busy, 0);

      // Push+pop at count=2, then pop at full
      a_valid = 1; a_rd = 20; b_valid = 1;
      b_rd = 12; b_data = 32'hC; step();
      b_rd = 13; b_data = 32'hD; step();
      a_valid = 0; b_rd = 14; b_data = 32'hE;
      step();
      chk("pp_wa", rf_wa, 12);
      chk("pp_busy", busy, 32'h6000);
      chk("pp_ready", b_ready, 1);
      a_valid = 1;
      b_rd = 15; b_data = 32'hF; step();
      b_rd = 16; b_data = 32'h10; step();
      chk("full_ready", b_ready, 0);
      chk("full_busy", busy, 32'h1E000);
      a_valid = 0; b_rd = 17; b_data = 32'h11;
      step();
      b_valid = 0;
      chk("full_pop_wa", rf_wa, 13);
      chk("full_pop_ready", b_ready, 1);
      chk("full_no_push", busy, 32'h1C000);
      for (int i = 14; i <= 16; i++) begin
         step();
         chk("full_drain_wa", rf_wa, 32'(i));
      end
      step();
      chk("full_idle_busy", busy, 0);

      // Duplicate rd and x0 entry
      a_valid = 1; a_rd = 20; b_valid = 1;
      b_rd = 9; b_data = 32'h901; step();
      b_rd = 9; b_data = 32'h902; step();
      b_rd = 0; b_data = 32'hABC; step();
      b_valid = 0; a_valid = 0; q_rs1 = 0; q_rs2 = 9;
      chk("dup_busy", busy, 32'h200);
      step();
      chk("dup1_din", rf_din, 32'h901);
      chk("dup1_busy", busy, 32'h200);
      chk("dup1_byp2", byp2_data, 32'h901);
      step();
      chk("dup2_din", rf_din, 32'h902);
      chk("dup2_busy", busy, 0);
      step();
      chk("x0_we", rf_we, 0);
      chk("x0_din", rf_din, 32'hABC);
      chk("x0_byp1", byp1_hit, 0);
      step();
      chk("x0_idle_we", rf_we, 0);

      // Reset mid-burst with three queued entries
      a_valid = 1; a_rd = 20; b_valid = 1;
      for (int i = 21; i <= 23; i++) begin
         b_rd = 5'(i); b_data = 32'(i);
         step();
      end
      chk("mid_busy", busy, 32'hE00000);
      rst_n = 0;
      #1;
      chk("mid_rst_we", rf_we, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_ready", b_ready, 1);
      chk("mid_rst_starve", b_starve, 0);
      step();
      a_valid = 0; b_valid = 0;
      rst_n = 1;
      step();
      chk("post_rst_we", rf_we, 0);
      chk("post_rst_busy", busy, 0);

      chk("order_contract", 32'(n_viol), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
